// File: rtl/an37_tile_loader.sv
// -----------------------------------------------------------------------------
// an37_tile_loader
//   Upstream stage of the 6x6 A=37 AN-code tile decoder. Serial codewords
//   arrive on a valid/ready stream and are assembled row-major into a tile of
//   ROWS*COLS entries. Two banks alternate: one fills while the other is held
//   for the decoder. Entry k = r*COLS+c sits at tile_data[k*CW_W +: CW_W].
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   s_valid      in   input codeword valid
//   s_data       in   input codeword (CW_W bits)
//   s_last       in   last codeword of the tile
//   s_ready      out  loader accepts s_data this cycle (registered)
//   tile_valid   out  tile_data holds a complete tile (registered)
//   tile_data    out  flat tile, ROWS*COLS*CW_W bits (registered)
//   tile_ready   in   decoder consumes the presented tile this cycle
//   frame_err    out  one-cycle pulse when s_last disagrees with word index
//   tile_cnt     out  tiles completed since reset, wraps at 16 bits
// -----------------------------------------------------------------------------
module an37_tile_loader #(
  parameter int CW_W = 18,
  parameter int ROWS = 6,
  parameter int COLS = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  input  logic [CW_W-1:0]               s_data,
  input  logic                          s_last,
  output logic                          s_ready,
  output logic                          tile_valid,
  output logic [ROWS*COLS*CW_W-1:0]     tile_data,
  input  logic                          tile_ready,
  output logic                          frame_err,
  output logic [15:0]                   tile_cnt
);

  localparam int N     = ROWS * COLS;
  localparam int TW    = N * CW_W;
  localparam int IDX_W = $clog2(N);

  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  // Per-bank state encoding
  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_FILLING = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  // Registered state
  logic [TW-1:0]    r_bank [2];
  logic [1:0]       r_state [2];
  logic [IDX_W-1:0] r_idx;
  logic             r_wr_bank;
  logic             r_rd_bank;
  logic             r_s_ready;
  logic             r_tile_valid;
  logic [TW-1:0]    r_tile_data;
  logic             r_frame_err;
  logic [15:0]      r_tile_cnt;

  // Next-state values
  logic             w_accept;
  logic             w_consume;
  logic             w_at_last;
  logic             w_complete;
  logic             w_early;
  logic             w_missing;
  logic [TW-1:0]    w_bank_nxt [2];
  logic [1:0]       w_state_nxt [2];
  logic [IDX_W-1:0] w_idx_nxt;
  logic             w_wr_bank_nxt;
  logic             w_rd_bank_nxt;
  logic             w_s_ready_nxt;
  logic             w_tile_valid_nxt;
  logic [TW-1:0]    w_tile_data_nxt;
  logic [15:0]      w_tile_cnt_nxt;

  // Handshake decode. r_s_ready already guarantees the write bank is not
  // FULL and r_tile_valid guarantees the read bank is FULL, so an accept and
  // a consume can never target the same bank in one edge.
  always_comb begin
    w_accept   = s_valid & r_s_ready;
    w_consume  = r_tile_valid & tile_ready;
    w_at_last  = (r_idx == IDX_LAST);
    w_complete = w_accept & (s_last | w_at_last);
    w_early    = w_accept & s_last & ~w_at_last;
    w_missing  = w_accept & ~s_last & w_at_last;
  end

  // Bank contents: write the accepted word; an early s_last zero-fills the
  // rest of the tile so the decoder sees valid (zero) codewords there.
  always_comb begin
    w_bank_nxt[0] = r_bank[0];
    w_bank_nxt[1] = r_bank[1];
    if (w_accept) begin
      for (int k = 0; k < N; k++) begin
        if (IDX_W'(k) == r_idx) begin
          w_bank_nxt[r_wr_bank][k*CW_W +: CW_W] = s_data;
        end else if (w_early && (IDX_W'(k) > r_idx)) begin
          w_bank_nxt[r_wr_bank][k*CW_W +: CW_W] = '0;
        end else begin
          w_bank_nxt[r_wr_bank][k*CW_W +: CW_W] = r_bank[r_wr_bank][k*CW_W +: CW_W];
        end
      end
    end else begin
      w_bank_nxt[r_wr_bank] = r_bank[r_wr_bank];
    end
  end

  // Bank states, pointers, index and counter
  always_comb begin
    w_state_nxt[0] = r_state[0];
    w_state_nxt[1] = r_state[1];
    if (w_consume) begin
      w_state_nxt[r_rd_bank] = ST_EMPTY;
    end else begin
      w_state_nxt[r_rd_bank] = r_state[r_rd_bank];
    end
    if (w_complete) begin
      w_state_nxt[r_wr_bank] = ST_FULL;
    end else if (w_accept) begin
      w_state_nxt[r_wr_bank] = ST_FILLING;
    end else begin
      w_state_nxt[r_wr_bank] = w_state_nxt[r_wr_bank];
    end

    if (w_complete) begin
      w_idx_nxt      = '0;
      w_wr_bank_nxt  = ~r_wr_bank;
      w_tile_cnt_nxt = r_tile_cnt + 16'd1;
    end else if (w_accept) begin
      w_idx_nxt      = r_idx + IDX_ONE;
      w_wr_bank_nxt  = r_wr_bank;
      w_tile_cnt_nxt = r_tile_cnt;
    end else begin
      w_idx_nxt      = r_idx;
      w_wr_bank_nxt  = r_wr_bank;
      w_tile_cnt_nxt = r_tile_cnt;
    end

    if (w_consume) begin
      w_rd_bank_nxt = ~r_rd_bank;
    end else begin
      w_rd_bank_nxt = r_rd_bank;
    end
  end

  // Output look-ahead: outputs are registered from post-edge bank state so
  // a completed tile is visible right after the completing edge.
  always_comb begin
    w_s_ready_nxt    = (w_state_nxt[w_wr_bank_nxt] != ST_FULL);
    w_tile_valid_nxt = (w_state_nxt[w_rd_bank_nxt] == ST_FULL);
    if (w_rd_bank_nxt) begin
      w_tile_data_nxt = w_bank_nxt[1];
    end else begin
      w_tile_data_nxt = w_bank_nxt[0];
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank[0]    <= '0;
      r_bank[1]    <= '0;
      r_state[0]   <= ST_EMPTY;
      r_state[1]   <= ST_EMPTY;
      r_idx        <= '0;
      r_wr_bank    <= 1'b0;
      r_rd_bank    <= 1'b0;
      r_s_ready    <= 1'b0;
      r_tile_valid <= 1'b0;
      r_tile_data  <= '0;
      r_frame_err  <= 1'b0;
      r_tile_cnt   <= 16'd0;
    end else begin
      r_bank[0]    <= w_bank_nxt[0];
      r_bank[1]    <= w_bank_nxt[1];
      r_state[0]   <= w_state_nxt[0];
      r_state[1]   <= w_state_nxt[1];
      r_idx        <= w_idx_nxt;
      r_wr_bank    <= w_wr_bank_nxt;
      r_rd_bank    <= w_rd_bank_nxt;
      r_s_ready    <= w_s_ready_nxt;
      r_tile_valid <= w_tile_valid_nxt;
      r_tile_data  <= w_tile_data_nxt;
      r_frame_err  <= w_early | w_missing;
      r_tile_cnt   <= w_tile_cnt_nxt;
    end
  end

  assign s_ready    = r_s_ready;
  assign tile_valid = r_tile_valid;
  assign tile_data  = r_tile_data;
  assign frame_err  = r_frame_err;
  assign tile_cnt   = r_tile_cnt;

endmodule

// File: tb/tb_an37_tile_loader.sv
// Bench for an37_tile_loader. A monitor keeps a tile-level reference model
// (list of accepted words, list of completed tiles awaiting consumption) and
// compares the DUT outputs against it on every falling edge.
module tb_an37_tile_loader;

  localparam int CW_W = 18;
  localparam int N    = 36;
  localparam int TW   = N * CW_W;

  logic            clk;
  logic            rst_n;
  logic            s_valid;
  logic [CW_W-1:0] s_data;
  logic            s_last;
  logic            s_ready;
  logic            tile_valid;
  logic [TW-1:0]   tile_data;
  logic            tile_ready;
  logic            frame_err;
  logic [15:0]     tile_cnt;

  an37_tile_loader #(.CW_W(CW_W), .ROWS(6), .COLS(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .tile_valid (tile_valid),
    .tile_data  (tile_data),
    .tile_ready (tile_ready),
    .frame_err  (frame_err),
    .tile_cnt   (tile_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int rdy_mode = 1;   // 0: tile_ready low, 1: high, 2: random

  // Reference model state
  logic [CW_W-1:0] cur_words[$];
  logic [TW-1:0]   sb[$];
  int              exp_cnt   = 0;
  logic            exp_ferr  = 1'b0;
  logic            started   = 1'b0;

  task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // tile_ready driver
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: tile_ready = 1'b0;
      1: tile_ready = 1'b1;
      default: tile_ready = ($urandom_range(0, 2) == 0);
    endcase
  end

  // Monitor / scoreboard: compare, then advance the model across the next edge
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_s_ready", TW'(s_ready), '0);
      chk("rst_tile_valid", TW'(tile_valid), '0);
      chk("rst_tile_data", tile_data, '0);
      chk("rst_frame_err", TW'(frame_err), '0);
      chk("rst_tile_cnt", TW'(tile_cnt), '0);
      cur_words.delete();
      sb.delete();
      exp_cnt  = 0;
      exp_ferr = 1'b0;
      started  = 1'b0;
    end else begin
      logic exp_rdy;
      logic acc;
      logic [TW-1:0] t;
      exp_rdy = started && (sb.size() < 2);
      chk("s_ready", TW'(s_ready), TW'(exp_rdy));
      chk("tile_valid", TW'(tile_valid), TW'(sb.size() > 0));
      if (sb.size() > 0) chk("tile_data", tile_data, sb[0]);
      chk("frame_err", TW'(frame_err), TW'(exp_ferr));
      chk("tile_cnt", TW'(tile_cnt), TW'(16'(exp_cnt)));

      exp_ferr = 1'b0;
      acc = s_valid && exp_rdy;
      if (sb.size() > 0 && tile_ready) void'(sb.pop_front());
      if (acc) begin
        cur_words.push_back(s_data);
        if (s_last || cur_words.size() == N) begin
          exp_ferr = (s_last != (cur_words.size() == N));
          t = '0;
          for (int i = 0; i < cur_words.size(); i++) t[i*CW_W +: CW_W] = cur_words[i];
          sb.push_back(t);
          exp_cnt = (exp_cnt + 1) % 65536;
          cur_words.delete();
        end
      end
      started = 1'b1;
    end
  end

  int stall_total;

  task automatic send(input logic [CW_W-1:0] d, input logic l);
    int w;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    w = 0;
    @(negedge clk);
    while (!s_ready && w < 500) begin
      w++;
      @(negedge clk);
    end
    chk("send_handshake", TW'(s_ready), TW'(1'b1));
    stall_total += w;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int w;
    rdy_mode = 1;
    w = 0;
    @(negedge clk);
    while (sb.size() != 0 && w < 300) begin
      w++;
      @(negedge clk);
    end
    @(negedge clk);
    chk("drain_idle", TW'(tile_valid), '0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    idle(cycles);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    s_valid    = 1'b0;
    s_data     = '0;
    s_last     = 1'b0;
    tile_ready = 1'b0;
    stall_total = 0;
    do_reset(3);
    idle(1);

    // 1: basic tile 37*k, s_last on the final word
    rdy_mode = 1;
    for (int k = 0; k < N; k++) send(CW_W'(37 * k), (k == N - 1));
    drain();
    chk("t1_tile_cnt", TW'(tile_cnt), TW'(16'd1));

    // 2: decoder stalled, two tiles fill both banks, then back-to-back drain
    rdy_mode = 0;
    for (int k = 0; k < 2 * N; k++) send(CW_W'($urandom), (k % N == N - 1));
    idle(3);
    chk("t2_both_full_ready", TW'(s_ready), '0);
    drain();

    // 3: early s_last on word 10, followed by a full tile
    for (int k = 0; k < 11; k++) send(CW_W'(37 * (k + 1)), (k == 10));
    for (int k = 0; k < N; k++) send(CW_W'($urandom), (k == N - 1));
    drain();

    // 4: missing s_last
    for (int k = 0; k < N; k++) send(CW_W'($urandom), 1'b0);
    drain();

    // 5: mid-tile reset, then a clean tile
    for (int k = 0; k < 20; k++) send(CW_W'($urandom), 1'b0);
    do_reset(2);
    idle(1);
    for (int k = 0; k < N; k++) send(CW_W'(37 * (k + 100)), (k == N - 1));
    drain();
    chk("t5_tile_cnt", TW'(tile_cnt), TW'(16'd1));

    // 6: continuous stream of three tiles with no stall
    stall_total = 0;
    for (int k = 0; k < 3 * N; k++) send(CW_W'($urandom), (k % N == N - 1));
    chk("t6_no_stall", TW'(stall_total), '0);
    drain();

    // 7: randomized framing, gaps and decoder backpressure
    rdy_mode = 2;
    for (int k = 0; k < 400; k++) begin
      send(CW_W'($urandom), ($urandom_range(0, 19) == 0));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    send(CW_W'($urandom), 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
